// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3). One iteration per input bit,
// started by an init pulse and finished with a one-cycle done pulse.
module conversor_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                r_status;
  state_t                w_status_next;
  logic [WIDTH-1:0]      r_sh_bin;
  logic [4*DIGITS-1:0]   r_sh_bcd;
  logic [CW-1:0]         r_cnt;
  logic [4*DIGITS-1:0]   w_bcd_next;

  // Adds 3 to a nibble >= 5 and shifts it left, taking lsb as the new bit 0.
  // Bit 3 of the adjusted nibble leaves towards the next digit (it equals nib >= 5).
  function automatic logic [3:0] dabble(input logic [3:0] nib, input logic lsb);
    if (nib >= 4'd5)
      return {nib[2:0] + 3'd3, lsb};
    else
      return {nib[2:0], lsb};
  endfunction

  always_comb begin
    w_bcd_next = '0;
    w_bcd_next[3:0] = dabble(r_sh_bcd[3:0], r_sh_bin[WIDTH-1]);
    for (int i = 1; i < DIGITS; i++)
      w_bcd_next[4*i +: 4] = dabble(r_sh_bcd[4*i +: 4], r_sh_bcd[4*i-4 +: 4] >= 4'd5);
  end

  always_comb begin
    w_status_next = r_status;
    case (r_status)
      IDLE:    if (init) w_status_next = CONV;
      CONV:    if (r_cnt == CNT_LAST) w_status_next = IDLE;
      default: w_status_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_status <= IDLE;
    else     r_status <= w_status_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_bin <= '0;
      r_sh_bcd <= '0;
      r_cnt    <= '0;
      bcd      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_status)
        IDLE: begin
          done <= 1'b0;
          if (init) begin
            r_sh_bin <= bin;
            r_sh_bcd <= '0;
            r_cnt    <= CNT_INIT;
            busy     <= 1'b1;
          end
        end
        CONV: begin
          r_sh_bcd <= w_bcd_next;
          r_sh_bin <= {r_sh_bin[WIDTH-2:0], 1'b0};
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == CNT_LAST) begin
            bcd  <= w_bcd_next;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd.sv
// Bench for conversor_bcd: decimal reference model, exhaustive sweep, random values,
// back-to-back issue, ignored init while busy and asynchronous reset mid-conversion.
module tb_conversor_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic [11:0] bcd;
  logic        done;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  conversor_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .bin  (bin),
    .bcd  (bcd),
    .done (done),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_bcd(input int v);
    return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full single conversion with cycle-by-cycle busy/done checks
  task automatic do_conv(input int v, input string tag);
    @(negedge clk);
    init = 1'b1;
    bin  = v[7:0];
    @(negedge clk);
    init = 1'b0;
    bin  = 8'($urandom);
    chk({tag, "_busy_c0"}, 32'(busy), 32'd1);
    chk({tag, "_done_c0"}, 32'(done), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(busy), (k < 8) ? 32'd1 : 32'd0);
      chk({tag, "_done"}, 32'(done), (k == 8) ? 32'd1 : 32'd0);
      if (k == 8) begin
        chk({tag, "_bcd"}, 32'(bcd), ref_bcd(v));
        chk({tag, "_nib_le9"}, 32'((bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[11:8] <= 4'd9)), 32'd1);
      end
    end
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[4];
    int got;
    int last;
    int ndone;

    #1 rst = 1'b1;
    #1;
    chk("rst_bcd",  32'(bcd),  32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_conv(0, "zero");

    for (int v = 0; v < 256; v++) do_conv(v, "sweep");

    for (int n = 0; n < 40; n++) do_conv(int'($urandom_range(0, 255)), "rand");

    do_conv(15 * 15, "mult_15x15");
    do_conv(7 * 9, "mult_7x9");

    // init held high, bin alternating between results
    vals = '{42, 199, 42, 199};
    got  = 0;
    last = 0;
    @(negedge clk);
    init = 1'b1;
    bin  = 8'd42;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_bcd", 32'(bcd), ref_bcd(vals[got]));
        if (got > 0) chk("b2b_gap", 32'(c - last), 32'd9);
        last = c;
        got++;
        if (got < 4) bin = vals[got][7:0];
        else         init = 1'b0;
      end
    end
    init = 1'b0;
    chk("b2b_count", 32'(got), 32'd4);
    repeat (2) @(negedge clk);

    // init while busy is ignored
    @(negedge clk);
    init = 1'b1;
    bin  = 8'd128;
    @(negedge clk);
    init = 1'b0;
    bin  = 8'd0;
    repeat (3) @(negedge clk);
    init = 1'b1;
    bin  = 8'd77;
    @(negedge clk);
    init = 1'b0;
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ign_bcd", 32'(bcd), 32'h128);
      end
    end
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_busy_after", 32'(busy), 32'd0);

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    init = 1'b1;
    bin  = 8'd200;
    @(negedge clk);
    init = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_busy_pre", 32'(busy), 32'd1);
    chk("rst_mid_bcd_pre",  32'(bcd),  32'h128);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_bcd",  32'(bcd),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);
    do_conv(37, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conversor_bcd.md
# conversor_bcd

Sequential binary-to-BCD converter (shift-add-3, "double dabble") that sits directly downstream of the 4x4 shift-add multiplier in the ALU. It takes the multiplier's 8-bit `producto` and `done`, and produces packed decimal digits for the display stage. It uses the same `init`/`done` pulse handshake as the multiplier, so the multiplier's `done` wires straight into `init`. Conversion costs one clock per input bit.

## Interface
- `WIDTH`, 8: binary input width.
- `DIGITS`, 3: number of BCD output digits. Must satisfy DIGITS ≥ ceil(WIDTH·log10(2)); 255 needs 3.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `init` input 1: start request, sampled on the rising edge of `clk`.
- `bin` input WIDTH: unsigned binary value, captured on the edge that accepts `init`.
- `bcd` output 4·DIGITS: packed result. Bits [3:0] are units, [7:4] tens, [11:8] hundreds. Registered.
- `done` output 1: one-cycle pulse; `bcd` is valid and updated in that cycle.
- `busy` output 1: high while a conversion is in progress.

## Operation
- Internal registers:
  - `sh_bin` (WIDTH bits): binary shift register.
  - `sh_bcd` (4·DIGITS bits): BCD scratch register.
  - `cnt` (ceil(log2(WIDTH+1)) bits): iteration counter.
  - `status`: FSM state.
- FSM states: IDLE, CONV.
- IDLE:
  - `busy`=0.
  - If `init`=1: `sh_bin`←`bin`, `sh_bcd`←0, `cnt`←WIDTH, `busy`←1, go to CONV.
  - `done` is cleared on every edge spent in IDLE (it is high for at most one cycle).
- CONV, each edge:
  - Compute the adjusted nibbles: every nibble of `sh_bcd` that is ≥5 gets +3; nibbles <5 are unchanged.
  - Shift {adjusted `sh_bcd`, `sh_bin`} left by 1. The MSB of `sh_bin` enters the LSB of `sh_bcd`, and a 0 enters the LSB of `sh_bin`.
  - `cnt`←`cnt`−1.
  - When `cnt`=1 (last iteration): load the shifted BCD value into `bcd`, set `done`←1 and `busy`←0, go to IDLE.
- Arithmetic rules:
  - Nibble add is 4-bit; an adjusted nibble (5..9 → 8..12) never exceeds 4 bits, so no carry between nibbles.
  - Every output nibble is 0..9.
  - With default parameters the top bits of `bcd`[11:8] are ≤2.
- `init` while `busy`=1 is ignored. The conversion in flight and `bin` capture are unaffected.
- `bin` is read only on the accepting edge; later changes have no effect.
- `bcd` holds the last result until the next completion; it is never cleared by `init`.
- Reset, at any time including mid-conversion:
  - Asynchronously forces `status`=IDLE, `sh_bin`=0, `sh_bcd`=0, `cnt`=0, `bcd`=0, `done`=0, `busy`=0.
  - The conversion is abandoned with no `done`.

## Timing
- Reset values: `bcd`=0, `done`=0, `busy`=0.
- Label the edge accepting `init` as edge 0. Then:
  - Iterations happen on edges 1..WIDTH.
  - `bcd` and `done`=1 appear after edge WIDTH (edge 8 by default).
  - `done` drops after edge WIDTH+1.
- Latency from `init` to `done`: WIDTH cycles.
- `busy`: high after edge 0, low after edge WIDTH, so it deasserts in the same cycle `done` rises.
- Back-to-back: `init` held high during the `done` cycle is accepted at edge WIDTH+1. Minimum issue interval is WIDTH+1 cycles.
- Multiplier hookup: `bin`←`producto`, `init`←`done`. The multiplier's `producto` is stable before the rising edge on which its `done` is sampled high, so the capture at edge 0 is valid.

## Test plan
- Reset, then `bin`=0 with an `init` pulse → after 8 cycles `done` pulses for one cycle, `bcd`=0x000, `busy` high for exactly cycles 1–8.
- Sweep `bin`=0..255, one conversion each → every `bcd` equals the decimal digits of `bin`; checks include 9→0x009, 10→0x010, 99→0x099, 100→0x100, 255→0x255. No nibble exceeds 9.
- Chained with the multiplier, MA=15, MB=15 → `producto`=225, converter `bcd`=0x225. MA=7, MB=9 → 0x063.
- `init` held high continuously with `bin` alternating 42/199 → results 0x042, 0x199, 0x042… Consecutive `done` pulses are exactly 9 cycles apart.
- `bin`=128 accepted, then `init` pulsed with `bin`=77 at cycle 4 → the second `init` is ignored; the result is 0x128 with a single `done`.
- `bin`=200 accepted, `rst` asserted mid-conversion at cycle 5 → `busy`, `done` and `bcd` go to 0 immediately without waiting for a clock edge. No `done` follows. A fresh `init` with 37 yields 0x037 after 8 cycles.
